// File: rtl/hist_pair_packer_if.sv
// Result-path bundle between the histogram core, the pair packer and the result FIFO.
// master drives strobes/data into the packer; slave is the packer side.
interface hist_pair_packer_if;
  logic        clear;
  logic [15:0] freq_din;
  logic        freq_write;
  logic        freq_full_n;
  logic [15:0] mode_din;
  logic        mode_write;
  logic        mode_full_n;
  logic [31:0] out_data;
  logic        out_write;
  logic        out_full;
  logic [15:0] frame_len;
  logic [31:0] pair_count;
  logic        skew_err;

  modport master (
    output clear, freq_din, freq_write, mode_din, mode_write, out_full, frame_len,
    input  freq_full_n, mode_full_n, out_data, out_write, pair_count, skew_err
  );

  modport slave (
    input  clear, freq_din, freq_write, mode_din, mode_write, out_full, frame_len,
    output freq_full_n, mode_full_n, out_data, out_write, pair_count, skew_err
  );
endinterface

// File: rtl/hist_pair_packer.sv
// Pairs freq/mode results into {mode,freq} words, 2 cycles write-to-strobe; HIST_PACK_TRAILER_EN adds frame trailers.
// Stalls (out_write low, out_data held) while out_full is high or either queue is empty.
module hist_pair_packer #(
  parameter int DEPTH = 8
) (
  input logic               ui_clk,
  input logic               aresetn,
  hist_pair_packer_if.slave bus
);
  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT   = (AW+1)'(DEPTH);
  localparam logic [0:0]  ST_RUN     = 1'b0;
  localparam logic [0:0]  ST_TRAILER = 1'b1;

  logic [15:0]   r_fq_mem [DEPTH];
  logic [15:0]   r_mq_mem [DEPTH];
  logic [AW-1:0] r_fq_wp, r_fq_rp, r_mq_wp, r_mq_rp;
  logic [AW:0]   r_fq_cnt, r_mq_cnt;
  logic          r_freq_full_n, r_mode_full_n;
  logic [31:0]   r_out_data, r_pair_count;
  logic          r_out_write, r_skew_err;
  logic [0:0]    r_state;

  logic          w_fq_push, w_mq_push, w_pair, w_trl_due, w_trl_emit;
  logic [AW:0]   w_fq_cnt_nxt, w_mq_cnt_nxt;
  logic [31:0]   w_trl_word;

  assign w_fq_push  = bus.freq_write && r_freq_full_n && !bus.clear;
  assign w_mq_push  = bus.mode_write && r_mode_full_n && !bus.clear;
  // A due trailer blocks the next pair so it lands exactly on the frame boundary.
  assign w_pair     = (r_state == ST_RUN) && !w_trl_due && (r_fq_cnt != '0) &&
                      (r_mq_cnt != '0) && !bus.out_full;
  assign w_trl_emit = (r_state == ST_TRAILER) && !bus.out_full;

  assign w_fq_cnt_nxt = r_fq_cnt + (AW+1)'(w_fq_push) - (AW+1)'(w_pair);
  assign w_mq_cnt_nxt = r_mq_cnt + (AW+1)'(w_mq_push) - (AW+1)'(w_pair);

`ifdef HIST_PACK_TRAILER_EN
  logic [15:0] r_frame_cnt, r_frame_idx;

  assign w_trl_due  = (r_state == ST_RUN) && (bus.frame_len != 16'd0) &&
                      (r_frame_cnt == bus.frame_len);
  assign w_trl_word = {8'hA5, 8'h00, r_frame_idx};

  always_ff @(posedge ui_clk or negedge aresetn) begin
    if (!aresetn) begin
      r_frame_cnt <= '0;
      r_frame_idx <= '0;
    end else if (bus.clear) begin
      r_frame_cnt <= '0;
      r_frame_idx <= '0;
    end else if (w_trl_emit) begin
      r_frame_cnt <= '0;
      r_frame_idx <= r_frame_idx + 16'd1;
    end else if (w_pair) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end
`else
  logic [15:0] w_unused_frame_len;

  assign w_unused_frame_len = bus.frame_len;
  assign w_trl_due          = 1'b0;
  assign w_trl_word         = 32'h0;
`endif

  always_ff @(posedge ui_clk) begin
    if (w_fq_push) r_fq_mem[r_fq_wp] <= bus.freq_din;
    if (w_mq_push) r_mq_mem[r_mq_wp] <= bus.mode_din;
  end

  always_ff @(posedge ui_clk or negedge aresetn) begin
    if (!aresetn) begin
      r_fq_wp       <= '0;
      r_fq_rp       <= '0;
      r_fq_cnt      <= '0;
      r_mq_wp       <= '0;
      r_mq_rp       <= '0;
      r_mq_cnt      <= '0;
      r_freq_full_n <= 1'b0;
      r_mode_full_n <= 1'b0;
    end else if (bus.clear) begin
      r_fq_wp       <= '0;
      r_fq_rp       <= '0;
      r_fq_cnt      <= '0;
      r_mq_wp       <= '0;
      r_mq_rp       <= '0;
      r_mq_cnt      <= '0;
      r_freq_full_n <= 1'b1;
      r_mode_full_n <= 1'b1;
    end else begin
      if (w_fq_push) r_fq_wp <= r_fq_wp + 1'b1;
      if (w_mq_push) r_mq_wp <= r_mq_wp + 1'b1;
      if (w_pair) begin
        r_fq_rp <= r_fq_rp + 1'b1;
        r_mq_rp <= r_mq_rp + 1'b1;
      end
      r_fq_cnt      <= w_fq_cnt_nxt;
      r_mq_cnt      <= w_mq_cnt_nxt;
      r_freq_full_n <= (w_fq_cnt_nxt != FULL_CNT);
      r_mode_full_n <= (w_mq_cnt_nxt != FULL_CNT);
    end
  end

  always_ff @(posedge ui_clk or negedge aresetn) begin
    if (!aresetn) begin
      r_out_data   <= '0;
      r_out_write  <= 1'b0;
      r_pair_count <= '0;
      r_skew_err   <= 1'b0;
      r_state      <= ST_RUN;
    end else if (bus.clear) begin
      r_out_data   <= '0;
      r_out_write  <= 1'b0;
      r_pair_count <= '0;
      r_skew_err   <= 1'b0;
      r_state      <= ST_RUN;
    end else begin
      r_out_write <= w_pair || w_trl_emit;
      if (w_pair) begin
        r_out_data   <= {r_mq_mem[r_mq_rp], r_fq_mem[r_fq_rp]};
        r_pair_count <= r_pair_count + 32'd1;
      end else if (w_trl_emit) begin
        r_out_data <= w_trl_word;
      end
      if (w_trl_due)       r_state <= ST_TRAILER;
      else if (w_trl_emit) r_state <= ST_RUN;
      // One side backed up to the limit while the other never delivered.
      if (((r_fq_cnt == FULL_CNT) && (r_mq_cnt == '0)) ||
          ((r_mq_cnt == FULL_CNT) && (r_fq_cnt == '0)))
        r_skew_err <= 1'b1;
    end
  end

  assign bus.freq_full_n = r_freq_full_n;
  assign bus.mode_full_n = r_mode_full_n;
  assign bus.out_data    = r_out_data;
  assign bus.out_write   = r_out_write;
  assign bus.pair_count  = r_pair_count;
  assign bus.skew_err    = r_skew_err;
endmodule

// File: doc/hist_pair_packer.md
# hist_pair_packer

Downstream stage of the partial-histogram core. It accepts the core's two 16-bit result streams (frequency and mode), pairs them in arrival order and emits one 32-bit word per pair into the single-clock side of the result dual-clock FIFO, so the host reads both results from one pipe. An optional frame trailer word can be compiled in.

## Interface
- DEPTH, 8: entries per input queue; power of two, at least 2.
- ui_clk  in  1  system clock; all logic is on the rising edge.
- aresetn  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush of queues, counters, output register and sticky flags.
- freq_din  in  16  frequency result from the core.
- freq_write  in  1  frequency write strobe; accepted when high with freq_full_n high.
- freq_full_n  out  1  frequency queue can accept.
- mode_din  in  16  mode result from the core.
- mode_write  in  1  mode write strobe; accepted when high with mode_full_n high.
- mode_full_n  out  1  mode queue can accept.
- out_data  out  32  packed word.
- out_write  out  1  one-cycle write strobe to the result FIFO.
- out_full  in  1  result FIFO full.
- frame_len  in  16  pairs per frame; used only when the trailer is compiled in.
- pair_count  out  32  number of pair words emitted; wraps.
- skew_err  out  1  sticky flag: one queue full while the other is empty.

## Operation
- **Queues.** There are two independent FIFOs, each DEPTH × 16.
  - full_n = (count != DEPTH).
  - A write while full is ignored (this cannot happen with a conforming producer).
  - A push and a pop in the same cycle leave the count unchanged, and full_n does not deassert.
- **Pair condition.** Both queues are non-empty, out_full is low and the FSM is in RUN.
- **Pair issue.** When the pair condition holds:
  - Both queue heads are popped.
  - out_data is registered as {mode_head, freq_head}.
  - out_write is registered high.
  - pair_count increments.
- **Back pressure.** If the pair condition fails, out_write is registered low and out_data holds its value.
- **Throughput.** At most one word per cycle; back-to-back words are allowed.
- **FSM states.**
  - RUN → TRAILER when the frame pair counter reaches frame_len and frame_len is non-zero (trailer build only).
  - TRAILER → RUN after the trailer is emitted, which requires out_full to be low.
- **Trailer word.** Value {8'hA5, 8'h00, frame_idx[15:0]}.
  - Issuing it increments frame_idx, which wraps at 16 bits.
  - Issuing it resets the frame pair counter.
  - pair_count is not incremented.
- **frame_len changes.** Changing frame_len mid-frame takes effect on the next comparison. If the counter is already above the new value, no trailer is emitted until the counter wraps; the frame counter is 16 bits.
- **skew_err.** Set in any cycle where one queue has count == DEPTH and the other has count == 0. Cleared only by clear or aresetn.
- **clear.** Within one cycle: empties both queues, zeroes pair_count, frame_idx and the frame counter, drops out_write, and returns the FSM to RUN. Writes presented in the same cycle as clear are dropped.

## Timing
- **During aresetn low:**
  - out_write = 0, out_data = 0, pair_count = 0, skew_err = 0.
  - freq_full_n = 0 and mode_full_n = 0.
  - FSM = RUN.
- **After aresetn release:** full_n goes high at the first rising edge.
- **Latency.** Take edge E as the edge where the later half of a pair is sampled. The queue shows non-empty after E, the issue decision is made in the following cycle, and out_write is high for the cycle after edge E+1. Total: 2 cycles from write to strobe.
- **out_full** is sampled combinationally in the decision cycle. The result FIFO must assert full with at least one entry of headroom, so a word already registered is never lost.
- **Reset mid-operation** discards all queued data immediately (asynchronous). No partial word is emitted.

## Configuration
- HIST_PACK_TRAILER_EN.
  - Defined: the TRAILER state, frame counter, frame_idx and trailer words are built.
  - Undefined: the FSM stays in RUN permanently, frame_len is ignored, and the output is pair words only.

## Test plan
- **Single pair.**
  - Stimulus: freq 0x0012, then mode 0x0034 three cycles later, out_full low.
  - Required: one out_write carrying 0x00340012, 2 cycles after the mode write; pair_count = 1.
- **Back-to-back.**
  - Stimulus: 8 simultaneous freq/mode writes with values i and 0x100+i, out_full low.
  - Required: 8 consecutive strobes with words {0x100+i, i} in order, no gaps; pair_count = 8.
- **Skew.**
  - Stimulus: out_full low, 10 freq writes, 0 mode writes.
  - Required: freq_full_n falls after the 8th accepted write; skew_err = 1; no out_write. Later, clear → skew_err = 0 and freq_full_n = 1.
- **Back pressure.**
  - Stimulus: out_full high for 5 cycles during a 6-pair stream.
  - Required: no strobe while out_full is high; all 6 words emitted once each, in order.
- **Trailer (macro defined, frame_len = 3).**
  - Stimulus: 6 pairs.
  - Required: words P0, P1, P2, 0xA5000000, P3, P4, P5, 0xA5000001; pair_count = 6.
- **Reset mid-stream.**
  - Stimulus: aresetn low with 4 pairs queued and out_full high.
  - Required: all outputs at reset values immediately. After release, pair 0xBEEF/0xCAFE → word 0xCAFEBEEF and pair_count = 1.
